// File: rtl/phv_pkt_emitter_if.sv
// Bundled header, payload and output-stream handshakes of the PHV packet emitter.
// The master side drives the emitter's inputs; the slave side is the emitter itself.
interface phv_pkt_emitter_if #(
    parameter int HEAD_WIDTH = 1024,
    parameter int LEN_W      = 8
);
    logic                  i_phv_valid;
    logic [HEAD_WIDTH-1:0] i_phv;
    logic [LEN_W-1:0]      i_phv_len;
    logic                  o_phv_ready;
    logic                  i_pay_valid;
    logic [133:0]          i_pay;
    logic                  o_pay_ready;
    logic                  o_data_valid;
    logic [133:0]          o_data;
    logic                  i_data_ready;

    modport master (
        output i_phv_valid, i_phv, i_phv_len,
        input  o_phv_ready,
        output i_pay_valid, i_pay,
        input  o_pay_ready,
        input  o_data_valid, o_data,
        output i_data_ready
    );

    modport slave (
        input  i_phv_valid, i_phv, i_phv_len,
        output o_phv_ready,
        input  i_pay_valid, i_pay,
        output o_pay_ready,
        output o_data_valid, o_data,
        input  i_data_ready
    );
endinterface

// File: rtl/phv_pkt_emitter.sv
// Merges a deparsed header vector and a 134b payload beat stream into one gap-free
// 134b packet stream: header bytes first, then payload bytes realigned behind them.
module phv_pkt_emitter #(
    parameter int HEAD_WIDTH = 1024,
    parameter int LEN_W      = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    phv_pkt_emitter_if.slave bus
);
    localparam int MAX_B = HEAD_WIDTH / 8;
    localparam int LOW_W = HEAD_WIDTH - 128;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_FLUSH} state_t;

    // Mask selecting the first k bytes (from the top) of a 16-byte beat; k = 0..16.
    function automatic logic [127:0] f_mask(input logic [4:0] k);
        return {128{1'b1}} << (8 * (16 - int'(k)));
    endfunction

    state_t                r_state;
    state_t                w_nxt_state;
    logic [HEAD_WIDTH-1:0] r_phv;        // top 16 bytes double as the held-byte buffer
    logic [LEN_W-1:0]      r_hrem;
    logic [3:0]            r_res;
    logic [3:0]            r_flush_cnt;
    logic                  r_first;
    logic                  r_data_valid;
    logic [133:0]          r_data;

    logic                  w_load_ok;
    logic [LEN_W-1:0]      w_len;
    logic                  w_phv_acc;
    logic                  w_pay_acc;
    logic                  w_hdr_now;
    logic [127:0]          w_hold;
    logic [4:0]            w_pay_n;
    logic [127:0]          w_pay_m;
    logic [127:0]          w_comb;
    logic [127:0]          w_left;
    logic [4:0]            w_tot;
    logic [1:0]            w_pay_tag;
    logic                  w_pay_tail;
    logic                  w_fits;
    logic [1:0]            w_head_tag;
    logic                  w_emit;
    logic [133:0]          w_beat;

    assign w_load_ok  = !r_data_valid || bus.i_data_ready;
    assign w_len      = (bus.i_phv_len > LEN_W'(MAX_B)) ? LEN_W'(MAX_B) : bus.i_phv_len;
    assign w_phv_acc  = bus.i_phv_valid && bus.o_phv_ready;
    assign w_pay_acc  = bus.i_pay_valid && bus.o_pay_ready;
    // A long header starts emitting in the accept cycle when the output slot is free.
    assign w_hdr_now  = (w_len >= LEN_W'(16)) && w_load_ok;
    assign w_hold     = r_phv[HEAD_WIDTH-1 -: 128];
    assign w_pay_n    = {1'b0, bus.i_pay[131:128]} + 5'd1;
    assign w_pay_m    = bus.i_pay[127:0] & f_mask(w_pay_n);
    assign w_comb     = (w_hold & f_mask({1'b0, r_res})) | (w_pay_m >> (8 * int'(r_res)));
    assign w_left     = w_pay_m << (8 * (16 - int'(r_res)));
    assign w_tot      = {1'b0, r_res} + w_pay_n;
    assign w_pay_tag  = bus.i_pay[133:132];
    assign w_pay_tail = (w_pay_tag == 2'b10) || (w_pay_tag == 2'b11);
    assign w_fits     = (w_tot <= 5'd16);
    assign w_head_tag = r_first ? 2'b01 : 2'b00;

    assign bus.o_data_valid = r_data_valid;
    assign bus.o_data       = r_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_nxt_state;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_phv_acc) begin
                    if (w_hdr_now) w_nxt_state = (w_len < LEN_W'(32)) ? S_PAY : S_HDR;
                    else           w_nxt_state = (w_len >= LEN_W'(16)) ? S_HDR : S_PAY;
                end
            end
            S_HDR:   if (w_load_ok && (r_hrem < LEN_W'(32))) w_nxt_state = S_PAY;
            S_PAY:   if (w_pay_acc && w_pay_tail) w_nxt_state = w_fits ? S_IDLE : S_FLUSH;
            S_FLUSH: if (w_load_ok) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_phv_ready = !i_rst && (r_state == S_IDLE);
        bus.o_pay_ready = !i_rst && (r_state == S_PAY) && w_load_ok;
        w_emit          = 1'b0;
        w_beat          = '0;
        case (r_state)
            S_IDLE: begin
                if (w_phv_acc && w_hdr_now) begin
                    w_emit = 1'b1;
                    w_beat = {2'b01, 4'hF, bus.i_phv[HEAD_WIDTH-1 -: 128]};
                end
            end
            S_HDR: begin
                if (w_load_ok) begin
                    w_emit = 1'b1;
                    w_beat = {w_head_tag, 4'hF, w_hold};
                end
            end
            S_PAY: begin
                if (w_pay_acc) begin
                    w_emit = 1'b1;
                    if (w_pay_tail && w_fits)
                        w_beat = {(r_first ? 2'b11 : 2'b10), 4'(w_tot - 5'd1), w_comb};
                    else
                        w_beat = {w_head_tag, 4'hF, w_comb};
                end
            end
            S_FLUSH: begin
                if (w_load_ok) begin
                    w_emit = 1'b1;
                    w_beat = {2'b10, r_flush_cnt - 4'd1, w_hold & f_mask({1'b0, r_flush_cnt})};
                end
            end
            default: w_emit = 1'b0;
        endcase
    end

    // NOTE: the header/hold datapath is not reset; every field is rewritten on PHV
    // accept before it is read, so only control and output state need clearing.
    always_ff @(posedge i_clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_phv_acc) begin
                    r_res   <= w_len[3:0];
                    r_first <= !w_hdr_now;
                    if (w_hdr_now) begin
                        r_phv  <= bus.i_phv << 128;
                        r_hrem <= w_len - LEN_W'(16);
                    end else begin
                        r_phv  <= bus.i_phv;
                        r_hrem <= w_len;
                    end
                end
            end
            S_HDR: begin
                if (w_load_ok) begin
                    r_phv   <= r_phv << 128;
                    r_hrem  <= r_hrem - LEN_W'(16);
                    r_first <= 1'b0;
                end
            end
            S_PAY: begin
                if (w_pay_acc) begin
                    r_phv       <= {w_left, {LOW_W{1'b0}}};
                    r_first     <= 1'b0;
                    r_flush_cnt <= 4'(w_tot - 5'd16);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_valid <= 1'b0;
            r_data       <= '0;
        end else if (w_load_ok) begin
            r_data_valid <= w_emit;
            if (w_emit) r_data <= w_beat;
        end
    end
endmodule

// File: tb/tb_phv_pkt_emitter.sv
// Scoreboard bench for phv_pkt_emitter: a byte-level packet model pushes expected
// output beats when a packet is driven; a monitor pops and compares consumed beats.
module tb_phv_pkt_emitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phv_pkt_emitter_if #(.HEAD_WIDTH(1024), .LEN_W(8)) bus ();

    phv_pkt_emitter #(.HEAD_WIDTH(1024), .LEN_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [133:0] sb_q[$];
    int           rdy_mode = 0;   // 0: always ready, 1: random, 2: follow man_rdy
    logic         man_rdy  = 1'b1;
    bit           lat_chk  = 1'b0;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.i_data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0)      bus.i_data_ready = 1'b1;
            else if (rdy_mode == 1) bus.i_data_ready = ($urandom_range(3) != 0);
            else                    bus.i_data_ready = man_rdy;
        end
    end

    // Monitor: compare consumed beats, check stall stability and back-pressure.
    initial begin
        bit           prev_stall = 1'b0;
        logic [133:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && bus.o_data_valid)
                check("hold_stable", bus.o_data, prev_data);
            if (bus.o_data_valid && !bus.i_data_ready)
                check("pay_rdy_stall", 134'(bus.o_pay_ready), 134'(0));
            if (bus.o_data_valid && bus.i_data_ready) begin
                if (sb_q.size() == 0) check("extra_beat", 134'(sb_q.size()), 134'(1));
                else                  check("beat", bus.o_data, sb_q.pop_front());
            end
            prev_stall = bus.o_data_valid && !bus.i_data_ready;
            prev_data  = bus.o_data;
        end
    end

    task automatic send_pkt(input int len_raw, input int pay_n);
        logic [7:0]    hdr[128];
        logic [7:0]    pay[$];
        logic [7:0]    bq[$];
        logic [1023:0] phv;
        int            L, tot, nb, pb;
        bit            acc;
        L = (len_raw > 128) ? 128 : len_raw;
        for (int i = 0; i < 128; i++) begin
            hdr[i] = 8'($urandom);
            phv[1023 - 8*i -: 8] = hdr[i];
        end
        for (int i = 0; i < pay_n; i++) pay.push_back(8'($urandom));
        for (int i = 0; i < L; i++) bq.push_back(hdr[i]);
        for (int i = 0; i < pay_n; i++) bq.push_back(pay[i]);

        tot = bq.size();
        nb  = (tot + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            logic [127:0] d;
            int           cnt;
            d   = '0;
            cnt = (tot - 16*b > 16) ? 16 : tot - 16*b;
            for (int j = 0; j < cnt; j++) d[127 - 8*j -: 8] = bq[16*b + j];
            sb_q.push_back({(b == nb - 1), (b == 0), 4'(cnt - 1), d});
        end

        bus.i_phv       = phv;
        bus.i_phv_len   = 8'(len_raw);
        bus.i_phv_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge clk);
            acc = bus.o_phv_ready;
            @(posedge clk);
            #1;
        end
        bus.i_phv_valid = 1'b0;
        check("phv_acc", 134'(acc), 134'(1));
        if (lat_chk && L >= 16) check("phv_lat", 134'(bus.o_data_valid), 134'(1));

        pb = (pay_n + 15) / 16;
        for (int b = 0; b < pb; b++) begin
            logic [127:0] d;
            int           cnt;
            d   = '0;
            cnt = (pay_n - 16*b > 16) ? 16 : pay_n - 16*b;
            for (int j = 0; j < cnt; j++) d[127 - 8*j -: 8] = pay[16*b + j];
            bus.i_pay       = {(b == pb - 1), (b == 0), 4'(cnt - 1), d};
            bus.i_pay_valid = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 500 && !acc; c++) begin
                @(negedge clk);
                acc = bus.o_pay_ready;
                @(posedge clk);
                #1;
            end
            bus.i_pay_valid = 1'b0;
            check("pay_acc", 134'(acc), 134'(1));
            check("pay_lat", 134'(bus.o_data_valid), 134'(1));
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && sb_q.size() != 0; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("drain", 134'(sb_q.size()), 134'(0));
    endtask

    initial begin
        bit acc;
        bus.i_phv_valid = 1'b0;
        bus.i_phv       = '0;
        bus.i_phv_len   = '0;
        bus.i_pay_valid = 1'b0;
        bus.i_pay       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",     134'(bus.o_data_valid), 134'(0));
        check("rst_data",      bus.o_data, 134'(0));
        check("rst_phv_ready", 134'(bus.o_phv_ready), 134'(0));
        check("rst_pay_ready", 134'(bus.o_pay_ready), 134'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_phv_ready", 134'(bus.o_phv_ready), 134'(1));

        lat_chk = 1'b1;
        send_pkt(32, 32);
        send_pkt(14, 16);
        send_pkt(0, 48);
        send_pkt(5, 4);
        drain();

        lat_chk  = 1'b0;
        rdy_mode = 2;
        man_rdy  = 1'b1;
        fork
            send_pkt(20, 40);
            begin
                repeat (4) @(posedge clk);
                #1 man_rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 man_rdy = 1'b1;
            end
        join
        drain();

        // Abort a packet in PAY with reset; its stalled header beat must vanish.
        bus.i_phv       = {1024{1'b1}};
        bus.i_phv_len   = 8'd20;
        bus.i_phv_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge clk);
            acc = bus.o_phv_ready;
            @(posedge clk);
            #1;
        end
        bus.i_phv_valid = 1'b0;
        check("abort_phv_acc", 134'(acc), 134'(1));
        rst     = 1'b1;
        man_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid",     134'(bus.o_data_valid), 134'(0));
        check("abort_data",      bus.o_data, 134'(0));
        check("abort_phv_ready", 134'(bus.o_phv_ready), 134'(0));
        rst      = 1'b0;
        man_rdy  = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("post_rst_phv_ready", 134'(bus.o_phv_ready), 134'(1));

        lat_chk = 1'b1;
        send_pkt(16, 20);
        send_pkt(200, 3);
        drain();

        lat_chk  = 1'b0;
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) send_pkt($urandom_range(0, 140), $urandom_range(1, 70));
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
